antares_hilo_sequencer: RTL and testbench

//  Issue/completion controller for the EX-stage HILO resources: multiplier, divider and HILO write port.

---
 rtl/antares_hilo_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_antares_hilo_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/antares_hilo_sequencer.sv
// antares_hilo_sequencer
//   Issue/completion controller for the EX-stage HILO resources (multiplier,
//   divider, HILO write port). It starts multi-cycle MUL/MADD/MSUB/DIV ops,
//   holds the issuing instruction in EX until its result is written, and
//   discards results of flushed ops. A watchdog aborts any wait that never
//   completes.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ex_alu_operation    EX opcode (ALU_OP_* values below)
//   ex_b_is_zero        divisor is zero
//   ex_stall_ext        stall from other sources
//   ex_flush            EX flush
//   mult_ready          1-cycle pulse, multiplier result valid
//   div_done            1-cycle pulse, divider result valid
//   mult_start/_signed  multiplier start pulse and signedness
//   div_start/_signed   divider start pulse and signedness
//   hilo_we, hilo_sel   HILO write strobe and source select
//                       (0 none,1 MUL load,2 MUL add,3 MUL sub,4 DIV,5 MTHI,6 MTLO)
//   ex_request_stall    hold EX
//   busy                FSM is not IDLE
//   err_timeout         sticky watchdog error
//   dbg_state           current FSM state
//
// Handshake: mult_start/div_start are single-cycle commands with no
// back-pressure; mult_ready/div_done are single-cycle completions that are
// only honoured while the matching op is outstanding (wait or drain state).
module antares_hilo_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ex_alu_operation,
  input  logic       ex_b_is_zero,
  input  logic       ex_stall_ext,
  input  logic       ex_flush,
  input  logic       mult_ready,
  input  logic       div_done,
  output logic       mult_start,
  output logic       mult_signed,
  output logic       div_start,
  output logic       div_signed,
  output logic       hilo_we,
  output logic [2:0] hilo_sel,
  output logic       ex_request_stall,
  output logic       busy,
  output logic       err_timeout,
  output logic [2:0] dbg_state
);

  localparam logic [4:0] ALU_OP_MULS  = 5'd16;
  localparam logic [4:0] ALU_OP_MULU  = 5'd17;
  localparam logic [4:0] ALU_OP_MADD  = 5'd18;
  localparam logic [4:0] ALU_OP_MADDU = 5'd19;
  localparam logic [4:0] ALU_OP_MSUB  = 5'd20;
  localparam logic [4:0] ALU_OP_MSUBU = 5'd21;
  localparam logic [4:0] ALU_OP_DIV   = 5'd22;
  localparam logic [4:0] ALU_OP_DIVU  = 5'd23;
  localparam logic [4:0] ALU_OP_MTHI  = 5'd24;
  localparam logic [4:0] ALU_OP_MTLO  = 5'd25;
  localparam logic [4:0] ALU_OP_MFHI  = 5'd26;
  localparam logic [4:0] ALU_OP_MFLO  = 5'd27;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MULT_WAIT = 3'd1,
    S_DIV_WAIT  = 3'd2,
    S_HOLD      = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic            div_q, div_d;     // outstanding op belongs to the divider
  logic [WD_W-1:0] wd_q;
  logic            err_q, set_err;

  logic       op_mult, op_mult_sgn, op_div, op_hilo, en;
  logic       in_wait, next_wait, done, timeout;
  logic [2:0] mult_code;

  always_comb begin
    op_mult = (ex_alu_operation >= ALU_OP_MULS) && (ex_alu_operation <= ALU_OP_MSUBU);
    op_mult_sgn = (ex_alu_operation == ALU_OP_MULS) || (ex_alu_operation == ALU_OP_MADD) ||
                  (ex_alu_operation == ALU_OP_MSUB);
    op_div  = (ex_alu_operation == ALU_OP_DIV) || (ex_alu_operation == ALU_OP_DIVU);
    op_hilo = (ex_alu_operation >= ALU_OP_MULS) && (ex_alu_operation <= ALU_OP_MFLO);
    if ((ex_alu_operation == ALU_OP_MADD) || (ex_alu_operation == ALU_OP_MADDU))
      mult_code = 3'd2;
    else if ((ex_alu_operation == ALU_OP_MSUB) || (ex_alu_operation == ALU_OP_MSUBU))
      mult_code = 3'd3;
    else
      mult_code = 3'd1;
  end

  // Own stall is deliberately excluded from en to avoid a combinational loop.
  assign en      = ~ex_stall_ext & ~ex_flush;
  assign in_wait = (state_q == S_MULT_WAIT) || (state_q == S_DIV_WAIT) || (state_q == S_DRAIN);
  assign done    = div_q ? div_done : mult_ready;
  assign timeout = in_wait && (wd_q == WD_W'(TIMEOUT - 1));
  assign next_wait = (state_d == S_MULT_WAIT) || (state_d == S_DIV_WAIT) || (state_d == S_DRAIN);

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    div_d            = div_q;
    set_err          = 1'b0;
    mult_start       = 1'b0;
    mult_signed      = 1'b0;
    div_start        = 1'b0;
    div_signed       = 1'b0;
    hilo_we          = 1'b0;
    hilo_sel         = 3'd0;
    ex_request_stall = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_mult) begin
          // Stall follows the opcode alone so a stalled op stays put.
          ex_request_stall = 1'b1;
          if (en) begin
            mult_start  = 1'b1;
            mult_signed = op_mult_sgn;
            sel_d       = mult_code;
            div_d       = 1'b0;
            state_d     = S_MULT_WAIT;
          end
        end else if (op_div && !ex_b_is_zero) begin
          ex_request_stall = 1'b1;
          if (en) begin
            div_start  = 1'b1;
            div_signed = (ex_alu_operation == ALU_OP_DIV);
            sel_d      = 3'd4;
            div_d      = 1'b1;
            state_d    = S_DIV_WAIT;
          end
        end else if (en && (ex_alu_operation == ALU_OP_MTHI)) begin
          hilo_we  = 1'b1;
          hilo_sel = 3'd5;
        end else if (en && (ex_alu_operation == ALU_OP_MTLO)) begin
          hilo_we  = 1'b1;
          hilo_sel = 3'd6;
        end
      end

      S_MULT_WAIT, S_DIV_WAIT: begin
        if (done && !ex_flush) begin
          hilo_we  = 1'b1;
          hilo_sel = sel_q;
          // HOLD keeps a still-stalled instruction from being issued again.
          state_d  = ex_stall_ext ? S_HOLD : S_IDLE;
        end else if (done) begin
          state_d = S_IDLE;
        end else if (timeout) begin
          set_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          ex_request_stall = 1'b1;
          if (ex_flush) state_d = S_DRAIN;
        end
      end

      S_HOLD: begin
        if (!ex_stall_ext) state_d = S_IDLE;
      end

      S_DRAIN: begin
        // Abandoned result still has to land; keep other HILO users out.
        if (done) begin
          ex_request_stall = op_hilo;
          state_d          = S_IDLE;
        end else if (timeout) begin
          set_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          ex_request_stall = op_hilo;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      mult_start       = 1'b0;
      mult_signed      = 1'b0;
      div_start        = 1'b0;
      div_signed       = 1'b0;
      hilo_we          = 1'b0;
      hilo_sel         = 3'd0;
      ex_request_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 3'd0;
      div_q   <= 1'b0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      div_q   <= div_d;
      // Count the whole outstanding period, including a wait->drain hop.
      wd_q    <= (in_wait && next_wait) ? wd_q + 1'b1 : '0;
      err_q   <= err_q | set_err;
    end
  end

  assign busy        = ~rst & (state_q != S_IDLE);
  assign err_timeout = ~rst & err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_antares_hilo_sequencer.sv
module tb_antares_hilo_sequencer;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_MULS  = 5'd16;
  localparam logic [4:0] OP_MULU  = 5'd17;
  localparam logic [4:0] OP_MADD  = 5'd18;
  localparam logic [4:0] OP_DIV   = 5'd22;
  localparam logic [4:0] OP_DIVU  = 5'd23;
  localparam logic [4:0] OP_MTHI  = 5'd24;
  localparam logic [4:0] OP_MTLO  = 5'd25;
  localparam logic [4:0] OP_MFHI  = 5'd26;
  localparam logic [4:0] OP_MFLO  = 5'd27;

  logic       clk, rst;
  logic [4:0] op;
  logic       b_zero, stall_ext, flush, mult_ready, div_done;
  logic       mult_start, mult_signed, div_start, div_signed, hilo_we;
  logic [2:0] hilo_sel, dbg_state;
  logic       stall, busy, err_timeout;

  int total = 0;
  int bad   = 0;

  antares_hilo_sequencer #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .ex_alu_operation(op), .ex_b_is_zero(b_zero),
    .ex_stall_ext(stall_ext), .ex_flush(flush), .mult_ready(mult_ready),
    .div_done(div_done), .mult_start(mult_start), .mult_signed(mult_signed),
    .div_start(div_start), .div_signed(div_signed), .hilo_we(hilo_we),
    .hilo_sel(hilo_sel), .ex_request_stall(stall), .busy(busy),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Inputs change at posedge+1; outputs are sampled at the following negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = OP_NOP; b_zero = 0; stall_ext = 0; flush = 0; mult_ready = 0; div_done = 0;
    tick(); tick();
    settle();
    total++;
    if ({mult_start, div_start, hilo_we, hilo_sel, stall, busy, err_timeout} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {mult_start, div_start, hilo_we, hilo_sel, stall, busy, err_timeout});
    end
    tick(); rst = 1'b0; settle();
    total++;
    if (busy !== 1'b0 || dbg_state !== 3'd0) begin
      bad++; $display("FAIL reset_idle: busy=%b state=%0d want 0/0", busy, dbg_state);
    end
    tick();
  endtask

  task automatic test_mulu();
    op = OP_MULU; settle();
    total++;
    if ({mult_start, mult_signed, stall, div_start} !== 4'b1010) begin
      bad++; $display("FAIL mulu_issue: start,sgn,stall,dstart=%b want 1010", {mult_start, mult_signed, stall, div_start});
    end
    for (int c = 1; c <= 3; c++) begin
      tick(); settle();
      total++;
      if ({stall, mult_start, hilo_we} !== 3'b100) begin
        bad++; $display("FAIL mulu_wait c%0d: stall,start,we=%b want 100", c, {stall, mult_start, hilo_we});
      end
    end
    tick(); mult_ready = 1; settle();
    total++;
    if ({hilo_we, hilo_sel, stall} !== 5'b1_001_0) begin
      bad++; $display("FAIL mulu_done: we,sel,stall=%b want 10010", {hilo_we, hilo_sel, stall});
    end
    tick(); mult_ready = 0; op = OP_NOP; settle();
    total++;
    if (busy !== 1'b0 || hilo_we !== 1'b0) begin
      bad++; $display("FAIL mulu_idle: busy=%b we=%b want 0/0", busy, hilo_we);
    end
    tick();
  endtask

  task automatic test_madd_hold();
    int we_count = 0, start_count = 0;
    op = OP_MADD; settle();
    total++;
    if ({mult_start, mult_signed} !== 2'b11) begin
      bad++; $display("FAIL madd_issue: start,sgn=%b want 11", {mult_start, mult_signed});
    end
    tick(); settle();
    tick(); mult_ready = 1; stall_ext = 1; settle();
    total++;
    if ({hilo_we, hilo_sel, stall} !== 5'b1_010_0) begin
      bad++; $display("FAIL madd_done: we,sel,stall=%b want 10100", {hilo_we, hilo_sel, stall});
    end
    tick(); mult_ready = 0;
    for (int c = 3; c <= 5; c++) begin
      stall_ext = (c < 5);
      settle();
      if (hilo_we) we_count++;
      if (mult_start) start_count++;
      total++;
      if (dbg_state !== 3'd3 || stall !== 1'b0) begin
        bad++; $display("FAIL madd_hold c%0d: state=%0d stall=%b want 3/0", c, dbg_state, stall);
      end
      tick();
    end
    total++;
    if (we_count !== 0 || start_count !== 0) begin
      bad++; $display("FAIL madd_no_repeat: we=%0d start=%0d want 0/0", we_count, start_count);
    end
    op = OP_NOP; settle();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL madd_release: busy=%b want 0", busy);
    end
    tick();
  endtask

  task automatic test_div_zero();
    op = OP_DIV; b_zero = 1; settle();
    total++;
    if ({div_start, hilo_we, stall} !== 3'b000) begin
      bad++; $display("FAIL div_zero: dstart,we,stall=%b want 000", {div_start, hilo_we, stall});
    end
    tick(); settle();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL div_zero_busy: busy=%b want 0", busy);
    end
    b_zero = 0; op = OP_NOP; tick();
  endtask

  task automatic test_divu();
    op = OP_DIVU; settle();
    total++;
    if ({div_start, div_signed, stall, mult_start} !== 4'b1010) begin
      bad++; $display("FAIL divu_issue: dstart,dsgn,stall,mstart=%b want 1010", {div_start, div_signed, stall, mult_start});
    end
    tick(); settle();
    tick(); mult_ready = 1; settle();   // wrong unit: must be ignored
    total++;
    if ({hilo_we, stall} !== 2'b01) begin
      bad++; $display("FAIL divu_wrong_unit: we,stall=%b want 01", {hilo_we, stall});
    end
    tick(); mult_ready = 0; div_done = 1; settle();
    total++;
    if ({hilo_we, hilo_sel, stall} !== 5'b1_100_0) begin
      bad++; $display("FAIL divu_done: we,sel,stall=%b want 11000", {hilo_we, hilo_sel, stall});
    end
    tick(); div_done = 0; op = OP_NOP; settle();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL divu_idle: busy=%b want 0", busy);
    end
    tick();
  endtask

  task automatic test_mt_mf();
    op = OP_MTHI; settle();
    total++;
    if ({hilo_we, hilo_sel, stall} !== 5'b1_101_0) begin
      bad++; $display("FAIL mthi: we,sel,stall=%b want 11010", {hilo_we, hilo_sel, stall});
    end
    tick(); op = OP_MTLO; stall_ext = 1; settle();
    total++;
    if (hilo_we !== 1'b0) begin
      bad++; $display("FAIL mtlo_stalled: we=%b want 0", hilo_we);
    end
    tick(); stall_ext = 0; settle();
    total++;
    if ({hilo_we, hilo_sel} !== 4'b1_110) begin
      bad++; $display("FAIL mtlo: we,sel=%b want 1110", {hilo_we, hilo_sel});
    end
    tick(); op = OP_MFHI; settle();
    total++;
    if ({hilo_we, stall, busy} !== 3'b000) begin
      bad++; $display("FAIL mfhi: we,stall,busy=%b want 000", {hilo_we, stall, busy});
    end
    op = OP_NOP; tick();
  endtask

  task automatic test_flush_drain();
    int we_count = 0;
    op = OP_MULS; settle();
    total++;
    if ({mult_start, mult_signed} !== 2'b11) begin
      bad++; $display("FAIL muls_issue: start,sgn=%b want 11", {mult_start, mult_signed});
    end
    tick(); settle();
    tick(); flush = 1; settle();
    if (hilo_we) we_count++;
    tick(); flush = 0; op = OP_MFLO;
    for (int c = 3; c <= 5; c++) begin
      mult_ready = (c == 5);
      settle();
      if (hilo_we) we_count++;
      total++;
      if (stall !== 1'b1) begin
        bad++; $display("FAIL drain_stall c%0d: stall=%b want 1", c, stall);
      end
      tick();
    end
    mult_ready = 0; settle();
    total++;
    if (stall !== 1'b0 || busy !== 1'b0 || we_count !== 0) begin
      bad++; $display("FAIL drain_free: stall=%b busy=%b we_cnt=%0d want 0/0/0", stall, busy, we_count);
    end
    op = OP_NOP; tick();
  endtask

  task automatic test_flush_with_done();
    op = OP_DIV; settle();
    total++;
    if ({div_start, div_signed} !== 2'b11) begin
      bad++; $display("FAIL div_issue: dstart,dsgn=%b want 11", {div_start, div_signed});
    end
    tick(); settle();
    tick(); flush = 1; div_done = 1; settle();
    total++;
    if (hilo_we !== 1'b0) begin
      bad++; $display("FAIL flush_done_we: we=%b want 0", hilo_we);
    end
    tick(); flush = 0; div_done = 0; op = OP_NOP; settle();
    total++;
    if (busy !== 1'b0 || hilo_we !== 1'b0) begin
      bad++; $display("FAIL flush_done_idle: busy=%b we=%b want 0/0", busy, hilo_we);
    end
    tick();
  endtask

  task automatic test_timeout();
    int early_bad = 0;
    op = OP_MULU; settle();
    for (int c = 1; c <= 63; c++) begin
      tick(); settle();
      if (stall !== 1'b1 || err_timeout !== 1'b0) early_bad++;
    end
    total++;
    if (early_bad !== 0) begin
      bad++; $display("FAIL timeout_early: %0d cycles wrong, want 0", early_bad);
    end
    tick(); settle();   // 64th cycle in wait
    total++;
    if ({stall, hilo_we, err_timeout} !== 3'b000) begin
      bad++; $display("FAIL timeout_release: stall,we,err=%b want 000", {stall, hilo_we, err_timeout});
    end
    tick(); op = OP_NOP; settle();
    total++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_err: err=%b busy=%b want 1/0", err_timeout, busy);
    end
    for (int c = 0; c < 5; c++) tick();
    mult_ready = 1; settle();
    total++;
    if (err_timeout !== 1'b1 || hilo_we !== 1'b0) begin
      bad++; $display("FAIL timeout_sticky: err=%b we=%b want 1/0", err_timeout, hilo_we);
    end
    tick(); mult_ready = 0; rst = 1; tick(); rst = 0; settle();
    total++;
    if (err_timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_rst_clear: err=%b want 0", err_timeout);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mulu();
    test_madd_hold();
    test_div_zero();
    test_divu();
    test_mt_mf();
    test_flush_drain();
    test_flush_with_done();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
